// File: rtl/jk_counter_pkg.sv
// Shared JK flip-flop control encoding for the JK counter family.
package jk_counter_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Drive a cell to a known target value regardless of its present state.
  function automatic logic [1:0] jk_force(input logic target);
    return target ? JK_SET : JK_CLR;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high clear.
module jk_cell (
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/jk_down_counter.sv
// Loadable modulo-MOD down counter built from JK cells, with zero flag and borrow pulse.
// Define JKDC_AUTORELOAD_EN to wrap to the last loaded value instead of MOD-1.
module jk_down_counter
  import jk_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             oe,
  output logic [WIDTH-1:0] dout,
  output logic             zero,
  output logic             bo
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

  logic [WIDTH-1:0]      count;
  logic [WIDTH-1:0]      count_n;
  logic [WIDTH-1:0]      din_sat;
  logic [WIDTH-1:0]      wrap_val;
  logic [WIDTH-1:0]      lower_zero;
  logic [WIDTH-1:0][1:0] jk_ctrl;
  logic                  bo_q;

  assign din_sat = (32'(din) < MOD) ? din : MaxVal;

`ifdef JKDC_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      reload_q <= MaxVal;
    end else if (ld) begin
      reload_q <= din_sat;
    end
  end

  assign wrap_val = reload_q;
`else
  assign wrap_val = MaxVal;
`endif

  assign zero = &count_n;

  always_comb begin
    lower_zero = '0;
    jk_ctrl    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Bit i toggles on decrement only when every lower bit is zero.
      lower_zero[i] = &(count_n | ~((WIDTH'(1) << i) - WIDTH'(1)));
      jk_ctrl[i]    = JK_HOLD;
      if (clr) begin
        jk_ctrl[i] = JK_HOLD;
      end else if (ld) begin
        jk_ctrl[i] = jk_force(din_sat[i]);
      end else if (en) begin
        if (zero) begin
          jk_ctrl[i] = jk_force(wrap_val[i]);
        end else if (lower_zero[i]) begin
          jk_ctrl[i] = JK_TGL;
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .clr (clr),
      .j   (jk_ctrl[g][1]),
      .k   (jk_ctrl[g][0]),
      .q   (count[g]),
      .qn  (count_n[g])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bo_q <= 1'b0;
    end else begin
      bo_q <= ~ld & en & zero;
    end
  end

  assign bo   = bo_q;
  assign dout = oe ? count : '0;

endmodule

// File: tb/tb_jk_down_counter.sv
// Directed self-checking bench for jk_down_counter (MOD=16 and MOD=10 instances).
module tb_jk_down_counter;

  logic       clk = 1'b0;
  logic       clr, en, ld, oe;
  logic [3:0] din;
  logic [3:0] dout, dout10;
  logic       zero, zero10, bo, bo10;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  jk_down_counter #(.WIDTH(4), .MOD(16)) dut (
    .clk  (clk),
    .clr  (clr),
    .en   (en),
    .ld   (ld),
    .din  (din),
    .oe   (oe),
    .dout (dout),
    .zero (zero),
    .bo   (bo)
  );

  jk_down_counter #(.WIDTH(4), .MOD(10)) dut10 (
    .clk  (clk),
    .clr  (clr),
    .en   (en),
    .ld   (ld),
    .din  (din),
    .oe   (oe),
    .dout (dout10),
    .zero (zero10),
    .bo   (bo10)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b1; ld = 1'b1; din = 4'd5; oe = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({dout, zero, bo} !== {4'd0, 1'b1, 1'b0})
        $display("FAIL reset cyc%0d: dout=%0d zero=%b bo=%b, need 0/1/0", c, dout, zero, bo);
      else passed++;
      checks++;
      if ({dout10, zero10, bo10} !== {4'd0, 1'b1, 1'b0})
        $display("FAIL reset10 cyc%0d: dout=%0d zero=%b bo=%b, need 0/1/0", c, dout10, zero10,
                 bo10);
      else passed++;
    end
    clr = 1'b0; en = 1'b0; ld = 1'b0;
    tick();
    checks++;
    if ({dout, zero, bo} !== {4'd0, 1'b1, 1'b0})
      $display("FAIL reset_release: dout=%0d zero=%b bo=%b, need 0/1/0", dout, zero, bo);
    else passed++;
  endtask

  task automatic test_load_count();
    logic [3:0] exp_d [6] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    logic       exp_z [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_b [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    oe = 1'b1; ld = 1'b1; din = 4'd3;
    tick();
    ld = 1'b0; en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({dout, zero, bo} !== {exp_d[c], exp_z[c], exp_b[c]})
        $display("FAIL load_count step%0d: dout=%0d zero=%b bo=%b, need %0d/%b/%b", c, dout,
                 zero, bo, exp_d[c], exp_z[c], exp_b[c]);
      else passed++;
      if (c < 5) tick();
    end
    en = 1'b0;
  endtask

  task automatic test_mod10();
    logic [3:0] exp_d;
    int         bo_seen;
    ld = 1'b1; din = 4'd12; en = 1'b1;
    tick();
    ld = 1'b0;
    checks++;
    if ({dout10, bo10} !== {4'd9, 1'b0})
      $display("FAIL mod10_saturate: dout=%0d bo=%b, need 9/0", dout10, bo10);
    else passed++;
    exp_d   = 4'd9;
    bo_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_d = (exp_d == 4'd0) ? 4'd9 : exp_d - 4'd1;
      if (bo10) bo_seen++;
      checks++;
      if ({dout10, zero10, bo10} !== {exp_d, exp_d == 4'd0, exp_d == 4'd9})
        $display("FAIL mod10_count step%0d: dout=%0d zero=%b bo=%b, need %0d", c, dout10, zero10,
                 bo10, exp_d);
      else passed++;
    end
    checks++;
    if (bo_seen !== 2) $display("FAIL mod10_bo_count: got %0d pulses, need 2", bo_seen);
    else passed++;
    en = 1'b0;
  endtask

  task automatic test_priority();
    ld = 1'b1; din = 4'd2; en = 1'b0;
    tick();
    din = 4'd7; en = 1'b1;
    tick();
    checks++;
    if ({dout, bo} !== {4'd7, 1'b0})
      $display("FAIL prio_ld_over_en: dout=%0d bo=%b, need 7/0", dout, bo);
    else passed++;
    clr = 1'b1;
    tick();
    clr = 1'b0; ld = 1'b0; en = 1'b0;
    checks++;
    if ({dout, zero} !== {4'd0, 1'b1})
      $display("FAIL prio_clr_over_ld: dout=%0d zero=%b, need 0/1", dout, zero);
    else passed++;
  endtask

  task automatic test_oe_gating();
    oe = 1'b1; ld = 1'b1; din = 4'd6;
    tick();
    ld = 1'b0; en = 1'b1; oe = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({dout, zero, bo} !== {4'd0, 1'b0, 1'b0})
        $display("FAIL oe_gated step%0d: dout=%0d zero=%b bo=%b, need 0/0/0", c, dout, zero, bo);
      else passed++;
    end
    en = 1'b0;
    tick();
    tick();
    oe = 1'b1;
    #1;
    checks++;
    if ({dout, bo} !== {4'd3, 1'b0})
      $display("FAIL oe_restore_hold: dout=%0d bo=%b, need 3/0", dout, bo);
    else passed++;
  endtask

  task automatic test_autoreload();
    logic [3:0] exp_d [7];
    logic [3:0] wrap;
`ifdef JKDC_AUTORELOAD_EN
    wrap = 4'd4;
`else
    wrap = 4'd15;
`endif
    exp_d = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, wrap, wrap - 4'd1};
    oe = 1'b1; ld = 1'b1; din = 4'd4; en = 1'b0;
    tick();
    ld = 1'b0; en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      checks++;
      if ({dout, bo} !== {exp_d[c], c == 5})
        $display("FAIL wrap_target step%0d: dout=%0d bo=%b, need %0d/%b", c, dout, bo, exp_d[c],
                 c == 5);
      else passed++;
      if (c < 6) tick();
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_count();
    test_mod10();
    test_priority();
    test_oe_gating();
    test_autoreload();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
